// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// One req/ack transaction at a time; mem_ack is a single-cycle pulse.
interface dmem_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_lsu.sv
// Memory-stage load/store unit: issues one req/ack bus access per instruction,
// stalls the pipe while it is outstanding and returns extended load data.
module dmem_lsu #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        load_sel_M,
  input  logic [2:0]        store_sel_M,
  input  logic              m_rnw,
  input  logic              flush_M,
  input  logic [31:0]       addr_M,
  input  logic [31:0]       wdata_M,
  dmem_lsu_if.master        mem,
  output logic              stall_M,
  output logic [31:0]       load_data_M,
  output logic              misalign_M,
  output logic              bus_err_M
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        ldata_q, ldata_d;
  logic [2:0]         ltype_q, ltype_d;
  logic [1:0]         off_q, off_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic       is_load, is_store, one_sel, misaligned, access_ok;
  logic [1:0] size;

  // size encoding shared by both selects: 00 byte, 01 half, 1x word
  always_comb begin
    is_load    = (load_sel_M != 3'b111);
    is_store   = (store_sel_M != 3'b111);
    one_sel    = is_load ^ is_store;
    size       = is_load ? load_sel_M[1:0] : store_sel_M[1:0];
    misaligned = ((size == 2'b01) && addr_M[0]) || (size[1] && (addr_M[1:0] != 2'b00));
    misalign_M = one_sel && !flush_M && misaligned;
    access_ok  = one_sel && !flush_M && !misaligned;
  end

  function automatic logic [31:0] extend(input logic [31:0] rdata,
                                         input logic [2:0]  ltype,
                                         input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (ltype[1:0])
      2'b00:   extend = ltype[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   extend = ltype[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: extend = rdata;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    ltype_d = ltype_q;
    off_d   = off_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stall_M = 1'b0;
    case (state_q)
      IDLE: begin
        stall_M = access_ok;
        if (access_ok) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = ~m_rnw;
          addr_d  = {addr_M[31:2], 2'b00};
          ltype_d = load_sel_M;
          off_d   = addr_M[1:0];
          cnt_d   = '0;
          case (store_sel_M[1:0])
            2'b00: begin
              be_d    = 4'b0001 << addr_M[1:0];
              wdata_d = {4{wdata_M[7:0]}};
            end
            2'b01: begin
              be_d    = 4'b0011 << addr_M[1:0];
              wdata_d = {2{wdata_M[15:0]}};
            end
            default: begin
              be_d    = '1;
              wdata_d = wdata_M;
            end
          endcase
          if (m_rnw) be_d = '1;
        end
      end
      BUSY: begin
        stall_M = 1'b1;
        // an ack in the final wait cycle still completes cleanly
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) ldata_d = extend(mem.mem_rdata, ltype_q, off_q);
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          ldata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      ltype_q <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      ltype_q <= ltype_d;
      off_q   <= off_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign load_data_M   = ldata_q;
  assign bus_err_M     = err_q;

endmodule
